// File: rtl/accum_window_delta.sv
// accum_window_delta
// Samples an upstream accumulator's running sum once per WINDOW enabled
// cycles and reports the amount added during each window (mod 2^WIDTH),
// together with a wrap indication. Results are held in a one-entry output
// register behind a valid/ready handshake; a sticky flag records any
// completed window that had to be dropped because the register was full.
module accum_window_delta #(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             delta_ready,
    output logic [WIDTH-1:0] delta_out,
    output logic             delta_valid,
    output logic             wrap_flag,
    output logic             overrun
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    // PRIME: waiting for the first completion to establish a baseline.
    // RUN:   every completion produces a result.
    localparam logic [0:0] PRIME = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] snap;
    logic [0:0]       state;

    logic             complete;
    logic             accept;
    logic             result_ready;
    logic [WIDTH-1:0] delta_next;
    logic             wrap_next;

    // Decode window completion, handshake acceptance and the new result.
    always_comb begin
        // NOTE: every signal gets a default at the top of the block so no
        // path can leave it unassigned and infer a latch.
        complete     = 1'b0;
        accept       = 1'b0;
        result_ready = 1'b0;
        delta_next   = '0;
        wrap_next    = 1'b0;

        complete     = enable && (cnt == LAST_CNT);
        accept       = delta_valid && delta_ready;
        result_ready = complete && (state == RUN);
        // Borrow is discarded: the difference is the window's sum mod 2^WIDTH.
        delta_next   = sum_in - snap;
        // A smaller sum than the baseline means the accumulator wrapped.
        wrap_next    = (sum_in < snap);
    end

    // Window counter: advances on enabled cycles, wraps after WINDOW-1.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST_CNT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Baseline tracking: every completion (kept or dropped) moves the
    // baseline, and the first one after reset only primes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap  <= '0;
            state <= PRIME;
        end else if (complete) begin
            snap  <= sum_in;
            state <= RUN;
        end
    end

    // One-entry output register with sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delta_out   <= '0;
            delta_valid <= 1'b0;
            wrap_flag   <= 1'b0;
            overrun     <= 1'b0;
        end else if (result_ready) begin
            if (!delta_valid || delta_ready) begin
                // Register empty, or being drained on this same edge.
                delta_out   <= delta_next;
                wrap_flag   <= wrap_next;
                delta_valid <= 1'b1;
            end else begin
                // Register still occupied: keep the old result, drop the new.
                overrun <= 1'b1;
            end
        end else if (accept) begin
            // Data and flag keep their last values once consumed.
            delta_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accum_window_delta.sv
// Directed bench for accum_window_delta (WIDTH=16, WINDOW=4).
// The upstream accumulator is modelled by `acc`: it adds `add` on every
// rising edge, and sum_in presents the value from before that edge.
module tb_accum_window_delta;

    localparam int WIDTH  = 16;
    localparam int WINDOW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] sum_in;
    logic             delta_ready;
    logic [WIDTH-1:0] delta_out;
    logic             delta_valid;
    logic             wrap_flag;
    logic             overrun;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] add;
    int               checks = 0;
    int               errors = 0;

    accum_window_delta #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sum_in      (sum_in),
        .delta_ready (delta_ready),
        .delta_out   (delta_out),
        .delta_valid (delta_valid),
        .wrap_flag   (wrap_flag),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic cycle(input logic en, input logic rdy);
        enable      = en;
        delta_ready = rdy;
        sum_in      = acc;
        @(posedge clk);
        #1;
        acc    = acc + add;
        sum_in = acc;
    endtask

    // Hold reset for one edge, then release with the accumulator at `start`.
    task automatic apply_reset(input logic [WIDTH-1:0] start);
        reset       = 1'b1;
        enable      = 1'b0;
        delta_ready = 1'b0;
        acc         = start;
        sum_in      = start;
        add         = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Reset values, silent priming window, then a result every 4 edges.
    task automatic test_reset_prime();
        logic exp_valid;
        apply_reset('0);
        checks++;
        if ({delta_out, delta_valid, wrap_flag, overrun} !== '0) begin
            $display("FAIL reset_values: out=%h valid=%b wrap=%b ovr=%b, need all 0",
                     delta_out, delta_valid, wrap_flag, overrun);
            errors++;
        end
        add = 16'd5;
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b1, 1'b1);
            exp_valid = (e == 8) || (e == 12);
            checks++;
            if (delta_valid !== exp_valid) begin
                $display("FAIL prime_valid edge %0d: got %b, need %b", e, delta_valid, exp_valid);
                errors++;
            end
            checks++;
            if (delta_out !== ((e >= 8) ? 16'd20 : 16'd0)) begin
                $display("FAIL prime_out edge %0d: got %0d, need %0d", e, delta_out,
                         (e >= 8) ? 20 : 0);
                errors++;
            end
            checks++;
            if (wrap_flag !== 1'b0 || overrun !== 1'b0) begin
                $display("FAIL prime_flags edge %0d: wrap=%b ovr=%b, need 0 0", e, wrap_flag, overrun);
                errors++;
            end
        end
    endtask

    // Baseline 0xFFF0, +9 per edge: completion sees 0x0014 -> delta 0x24 with wrap.
    task automatic test_wrap();
        apply_reset(16'hFFD5);
        add = 16'd9;
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b1, 1'b1);
            if (e == 4) begin
                checks++;
                if (delta_valid !== 1'b0) begin
                    $display("FAIL wrap_baseline: valid=%b, need 0", delta_valid);
                    errors++;
                end
            end
            if (e == 8 || e == 12) begin
                checks++;
                if (delta_valid !== 1'b1 || delta_out !== 16'h0024) begin
                    $display("FAIL wrap_delta edge %0d: valid=%b out=%h, need 1 0024",
                             e, delta_valid, delta_out);
                    errors++;
                end
                // Only the first window crosses 0xFFFF.
                checks++;
                if (wrap_flag !== (e == 8)) begin
                    $display("FAIL wrap_flag edge %0d: got %b, need %b", e, wrap_flag, (e == 8));
                    errors++;
                end
            end
        end
    endtask

    // Hold the first result across a second completion, then drain it.
    task automatic test_backpressure();
        apply_reset('0);
        add = 16'd5;
        for (int e = 1; e <= 8; e++) cycle(1'b1, 1'b0);
        checks++;
        if (delta_valid !== 1'b1 || delta_out !== 16'd20 || overrun !== 1'b0) begin
            $display("FAIL bp_first: valid=%b out=%0d ovr=%b, need 1 20 0",
                     delta_valid, delta_out, overrun);
            errors++;
        end
        // Edges 9..12 see 40,47,54,61; edge 12 completes with 26, which is dropped.
        add = 16'd7;
        for (int e = 9; e <= 12; e++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (delta_valid !== 1'b1 || delta_out !== 16'd20) begin
                $display("FAIL bp_hold edge %0d: valid=%b out=%0d, need 1 20", e, delta_valid, delta_out);
                errors++;
            end
            checks++;
            if (overrun !== (e == 12)) begin
                $display("FAIL bp_overrun edge %0d: got %b, need %b", e, overrun, (e == 12));
                errors++;
            end
        end
        // Accept on edge 13, then the next result (89-61=28) lands on edge 16.
        cycle(1'b1, 1'b1);
        checks++;
        if (delta_valid !== 1'b0 || delta_out !== 16'd20) begin
            $display("FAIL bp_accept: valid=%b out=%0d, need 0 20", delta_valid, delta_out);
            errors++;
        end
        for (int e = 14; e <= 16; e++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (delta_valid !== (e == 16)) begin
                $display("FAIL bp_next_valid edge %0d: got %b, need %b", e, delta_valid, (e == 16));
                errors++;
            end
        end
        checks++;
        if (delta_out !== 16'd28 || wrap_flag !== 1'b0 || overrun !== 1'b1) begin
            $display("FAIL bp_next: out=%0d wrap=%b ovr=%b, need 28 0 1", delta_out, wrap_flag, overrun);
            errors++;
        end
    endtask

    // Accept on the completion edge: new result replaces the old one cleanly.
    task automatic test_accept_and_complete();
        apply_reset('0);
        add = 16'd5;
        for (int e = 1; e <= 8; e++) cycle(1'b1, 1'b0);
        // Edges 9..12 see 40,43,46,49; edge 12 delta = 49-35 = 14.
        add = 16'd3;
        for (int e = 9; e <= 11; e++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        checks++;
        if (delta_valid !== 1'b1 || delta_out !== 16'd14 || overrun !== 1'b0) begin
            $display("FAIL acc_cmp_load: valid=%b out=%0d ovr=%b, need 1 14 0",
                     delta_valid, delta_out, overrun);
            errors++;
        end
        cycle(1'b1, 1'b1);
        checks++;
        if (delta_valid !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL acc_cmp_drain: valid=%b ovr=%b, need 0 0", delta_valid, overrun);
            errors++;
        end
    endtask

    // Enable low for edges 7..9 (input 0): completion moves from edge 8 to 11.
    // Between the baseline edge (sum 15) and edge 11 (sum 35) four enabled
    // edges each add 5, so the reported delta is 20.
    task automatic test_enable_gating();
        apply_reset('0);
        add = 16'd5;
        for (int e = 1; e <= 6; e++) cycle(1'b1, 1'b1);
        add = 16'd0;
        for (int e = 7; e <= 9; e++) begin
            cycle(1'b0, 1'b1);
            checks++;
            if (delta_valid !== 1'b0) begin
                $display("FAIL gate_frozen edge %0d: valid=%b, need 0", e, delta_valid);
                errors++;
            end
        end
        add = 16'd5;
        cycle(1'b1, 1'b1);
        checks++;
        if (delta_valid !== 1'b0) begin
            $display("FAIL gate_resume edge 10: valid=%b, need 0", delta_valid);
            errors++;
        end
        cycle(1'b1, 1'b1);
        checks++;
        if (delta_valid !== 1'b1 || delta_out !== 16'd20 || wrap_flag !== 1'b0) begin
            $display("FAIL gate_delta edge 11: valid=%b out=%0d wrap=%b, need 1 20 0",
                     delta_valid, delta_out, wrap_flag);
            errors++;
        end
    endtask

    // Asynchronous reset between edges, then a fresh priming window.
    task automatic test_reset_mid();
        apply_reset('0);
        add = 16'd5;
        for (int e = 1; e <= 14; e++) cycle(1'b1, 1'b0);
        checks++;
        if (delta_valid !== 1'b1 || overrun !== 1'b1) begin
            $display("FAIL mid_pre: valid=%b ovr=%b, need 1 1", delta_valid, overrun);
            errors++;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({delta_out, delta_valid, wrap_flag, overrun} !== '0) begin
            $display("FAIL mid_async: out=%h valid=%b wrap=%b ovr=%b, need all 0",
                     delta_out, delta_valid, wrap_flag, overrun);
            errors++;
        end
        #2 reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (delta_valid !== (e == 8)) begin
                $display("FAIL mid_reprime edge %0d: valid=%b, need %b", e, delta_valid, (e == 8));
                errors++;
            end
        end
        checks++;
        if (delta_out !== 16'd20 || overrun !== 1'b0) begin
            $display("FAIL mid_result: out=%0d ovr=%b, need 20 0", delta_out, overrun);
            errors++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        delta_ready = 1'b0;
        acc         = '0;
        add         = '0;
        sum_in      = '0;
        test_reset_prime();
        test_wrap();
        test_backpressure();
        test_accept_and_complete();
        test_enable_gating();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
